scroll_ctl: RTL and testbench

Frame-synchronous scroll scheduler for the tower background. It owns the vertical scroll position that `draw_background` consumes as `shift`, advances it once per frame at the start of vertical blanking, and ramps scroll speed over time. It also drains queued player-height "boost" pixels, so the picture never tears mid-frame. It runs in the `pclk` (135 MHz) domain beside `vga_timing`; its `shift` output replaces the free-running `vcount` slice.

---
 rtl/tower_pkg.sv | 22 ++
 rtl/frame_tick_gen.sv | 19 +
 rtl/scroll_ctl.sv | 140 ++++++++++++++
 tb/tb_scroll_ctl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tower_pkg.sv
// Shared tower types and widths: scroll FSM states and background offset geometry.
package tower_pkg;

    localparam int unsigned OFFSET_W = 10;
    localparam int unsigned SHIFT_W  = 6;
    localparam int unsigned FINE_W   = 4;
    localparam int unsigned SPEED_W  = 3;
    localparam int unsigned BOOST_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        PAUSED = 2'd3
    } scroll_state_t;

    // Clamp a 9-bit queue sum to the 8-bit boost range.
    function automatic logic [BOOST_W-1:0] sat_boost(input logic [BOOST_W:0] sum);
        return sum[BOOST_W] ? {BOOST_W{1'b1}} : sum[BOOST_W-1:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vertical blank; one combinational pulse per frame.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk_in,
    output logic tick_c
);

    logic vblnk_q;

    // Reset high so a blank already in progress at release is not a new frame.
    always_ff @(posedge clk) begin
        if (rst) vblnk_q <= 1'b1;
        else     vblnk_q <= vblnk_in;
    end

    assign tick_c = vblnk_in & ~vblnk_q;

endmodule

// File: rtl/scroll_ctl.sv
// Frame-synchronous scroll scheduler: owns the background offset, speed ramp and boost queue.
module scroll_ctl
    import tower_pkg::*;
#(
    parameter int unsigned FRAMES_PER_LEVEL = 750,
    parameter int unsigned MAX_SPEED        = 7,
    parameter int unsigned BOOST_STEP       = 4
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                vblnk_in,
    input  logic                start,
    input  logic                pause,
    input  logic                stop,
    input  logic                boost_valid,
    input  logic [BOOST_W-1:0]  boost_px,
    output logic [SHIFT_W-1:0]  shift,
    output logic [FINE_W-1:0]   fine,
    output logic [SPEED_W-1:0]  speed,
    output scroll_state_t       state,
    output logic                frame_tick,
    output logic                level_up
);

    localparam int unsigned FC_W = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;
    localparam logic [FC_W-1:0]    FC_LAST   = FC_W'(FRAMES_PER_LEVEL - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
    localparam logic [BOOST_W-1:0] DRAIN_MAX = BOOST_W'(BOOST_STEP);

    scroll_state_t       state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [BOOST_W-1:0]  pending_q, pending_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [SPEED_W-1:0]  speed_d;
    logic                level_up_d;

    logic                tick_c;
    logic [BOOST_W-1:0]  drain_c;
    logic [BOOST_W-1:0]  tick_drain_c;
    logic [BOOST_W-1:0]  boost_add_c;
    logic [BOOST_W:0]    pend_sum_c;
    logic [OFFSET_W:0]   off_sum_c;

    frame_tick_gen u_tick (
        .clk      (pclk),
        .rst      (rst),
        .vblnk_in (vblnk_in),
        .tick_c   (tick_c)
    );

    assign drain_c      = (pending_q < DRAIN_MAX) ? pending_q : DRAIN_MAX;
    assign tick_drain_c = tick_c ? drain_c : '0;
    assign boost_add_c  = boost_valid ? boost_px : '0;
    // drain never exceeds pending, so the 9-bit difference cannot underflow
    assign pend_sum_c   = (BOOST_W+1)'(pending_q) - (BOOST_W+1)'(tick_drain_c)
                        + (BOOST_W+1)'(boost_add_c);
    assign off_sum_c    = (OFFSET_W+1)'(offset_q) + (OFFSET_W+1)'(speed)
                        + (OFFSET_W+1)'(drain_c);

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        offset_d    = offset_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        speed_d     = speed;
        level_up_d  = 1'b0;

        unique case (state)
            IDLE: begin
                offset_d    = '0;
                pending_d   = '0;
                frame_cnt_d = '0;
                speed_d     = '0;
                if (start) state_d = ARMED;
            end
            ARMED: begin
                if (tick_c) begin
                    state_d = RUN;
                    speed_d = SPEED_W'(1);
                end
            end
            RUN: begin
                pending_d = sat_boost(pend_sum_c);
                if (tick_c) begin
                    offset_d = OFFSET_W'(off_sum_c);
                    if (frame_cnt_q == FC_LAST) begin
                        frame_cnt_d = '0;
                        if (speed < SPEED_MAX) begin
                            speed_d    = speed + SPEED_W'(1);
                            level_up_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                end
                if (pause) state_d = PAUSED;
            end
            PAUSED: begin
                if (pause) state_d = RUN;
            end
        endcase

        // stop overrides everything decided above
        if (stop) begin
            state_d     = IDLE;
            offset_d    = '0;
            pending_d   = '0;
            frame_cnt_d = '0;
            speed_d     = '0;
            level_up_d  = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            offset_q    <= '0;
            pending_q   <= '0;
            frame_cnt_q <= '0;
            speed       <= '0;
            level_up    <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            offset_q    <= offset_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            speed       <= speed_d;
            level_up    <= level_up_d;
            frame_tick  <= tick_c;
        end
    end

    assign shift = offset_q[OFFSET_W-1:FINE_W];
    assign fine  = offset_q[FINE_W-1:0];

endmodule

// File: tb/tb_scroll_ctl.sv
// Directed vector bench for scroll_ctl with a short frame-per-level count.
module tb_scroll_ctl;
    import tower_pkg::*;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vblnk_in = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       boost_valid = 1'b0;
    logic [7:0] boost_px = 8'd0;
    logic [5:0] shift;
    logic [3:0] fine;
    logic [2:0] speed;
    scroll_state_t state;
    logic       frame_tick;
    logic       level_up;

    int n_pass = 0;
    int n_total = 0;

    scroll_ctl #(
        .FRAMES_PER_LEVEL (4),
        .MAX_SPEED        (7),
        .BOOST_STEP       (4)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .vblnk_in    (vblnk_in),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .boost_valid (boost_valid),
        .boost_px    (boost_px),
        .shift       (shift),
        .fine        (fine),
        .speed       (speed),
        .state       (state),
        .frame_tick  (frame_tick),
        .level_up    (level_up)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic       vb, st, pa, sp, bv;
        logic [7:0] px;
        int         e_state, e_off, e_spd, e_ft, e_lu;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vb, st, pa, sp, bv, input logic [7:0] px,
                       input int es, eo, esp, eft, elu);
        vec_t v;
        v.vb = vb; v.st = st; v.pa = pa; v.sp = sp; v.bv = bv; v.px = px;
        v.e_state = es; v.e_off = eo; v.e_spd = esp; v.e_ft = eft; v.e_lu = elu;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic vb, st, pa, sp, bv, input logic [7:0] px);
        vblnk_in = vb; start = st; pause = pa; stop = sp; boost_valid = bv; boost_px = px;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic int off_now();
        return int'({shift, fine});
    endfunction

    task automatic chk_all(input string tag, input int es, eo, esp, eft, elu);
        chk({tag, " state"}, int'(state), es);
        chk({tag, " offset"}, off_now(), eo);
        chk({tag, " speed"}, int'(speed), esp);
        chk({tag, " frame_tick"}, int'(frame_tick), eft);
        chk({tag, " level_up"}, int'(level_up), elu);
    endtask

    initial begin
        int lu_cnt;
        int exp_spd;

        // Reset with vblank held high through release: no tick until it falls and rises.
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 0);
        chk("post-reset vb high ft0", int'(frame_tick), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("post-reset vb high ft1", int'(frame_tick), 0);
        cyc(0, 0, 0, 0, 0, 0);

        // vb  st pa sp bv px  | state off spd ft lu
        add(0, 1, 0, 0, 0, 0,    1,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2,  0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2,  0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2,  1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2,  1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2,  2, 1, 1, 0);
        add(0, 0, 0, 0, 1, 10,   2,  2, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2,  7, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2,  7, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 12, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0,    2, 12, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 16, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2, 16, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 18, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2, 18, 2, 0, 0);
        add(1, 0, 0, 0, 1, 3,    2, 20, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2, 20, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 25, 3, 1, 1);
        add(0, 0, 0, 0, 0, 0,    2, 25, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 28, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0,    3, 28, 3, 0, 0);
        add(1, 0, 0, 0, 1, 50,   3, 28, 3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            add(0, 0, 0, 0, 0, 0, 3, 28, 3, 0, 0);
            add(1, 0, 0, 0, 0, 0, 3, 28, 3, 1, 0);
        end
        add(0, 0, 1, 0, 0, 0,    2, 28, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 31, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2, 31, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 34, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,    2, 34, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 37, 4, 1, 1);
        add(0, 0, 0, 0, 0, 0,    2, 37, 4, 0, 0);
        add(1, 0, 1, 0, 0, 0,    3, 41, 4, 1, 0);
        add(0, 0, 1, 0, 0, 0,    2, 41, 4, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2, 45, 4, 1, 0);
        add(0, 0, 1, 1, 0, 0,    0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,    0,  0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,    1,  0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,    2,  0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0,    2,  0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    2,  1, 1, 1, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].vb, vecs[i].st, vecs[i].pa, vecs[i].sp, vecs[i].bv, vecs[i].px);
            chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_off,
                    vecs[i].e_spd, vecs[i].e_ft, vecs[i].e_lu);
        end

        // Speed ramp, saturated boost queue and offset wrap in one long run.
        cyc(0, 0, 0, 1, 0, 0);
        chk("stop to idle", int'(state), 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("ramp armed->run speed", int'(speed), 1);
        cyc(0, 0, 0, 0, 1, 200);
        cyc(0, 0, 0, 0, 1, 200);
        lu_cnt = 0;
        for (int n = 2; n <= 123; n++) begin
            cyc(0, 0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 0);
            exp_spd = 1 + (n - 1) / 4;
            if (exp_spd > 7) exp_spd = 7;
            chk($sformatf("ramp tick%0d speed", n), int'(speed), exp_spd);
            if (level_up) lu_cnt++;
            if (n == 2)   chk("ramp tick2 offset", off_now(), 5);
            if (n == 65)  chk("sat255 drained offset", off_now(), 619);
            if (n == 122) chk("pre-wrap offset", off_now(), 1018);
            if (n == 123) begin
                chk("wrap shift", int'(shift), 0);
                chk("wrap fine", int'(fine), 1);
            end
        end
        chk("level_up pulse count", lu_cnt, 6);

        // Reset mid-game while vblank is high, then hold high: no spurious tick.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        chk_all("midrst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk($sformatf("midrst hold%0d ft", i), int'(frame_tick), 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("midrst first tick", int'(frame_tick), 1);
        chk("midrst state idle", int'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
